ram_prog_ctrl: RTL and testbench

RAM_PROG_CTRL -- requirements
Module: ram_prog_ctrl

---
 rtl/cpu_pkg.sv | 15 +
 rtl/ram_prog_ctrl_if.sv | 34 +++
 rtl/btn_sync_edge.sv | 25 ++
 rtl/ram_prog_ctrl.sv | 108 ++++++++++
 tb/tb_ram_prog_ctrl.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU-board definitions: default bus/address widths, RAM depth and
// the programming controller state encoding.
package cpu_pkg;
  localparam int CPU_WIDTH  = 8;
  localparam int CPU_ADDR_W = CPU_WIDTH / 2;
  localparam int RAM_DEPTH  = 16;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ARMED  = 3'd1,
    WRITE  = 3'd2,
    VERIFY = 3'd3,
    INC    = 3'd4
  } prog_state_e;
endpackage

// File: rtl/ram_prog_ctrl_if.sv
// RAM programming bus bundle.
//   prog_mode : level, request programming mode
//   btn_wr    : raw write pushbutton
//   sw        : switch data written to RAM
//   bus       : shared CPU bus (observed only, carries RAM readback)
//   addr, prog_en, wr_en, rd_en : RAM controls
//   busy, done, err             : status
// master = the controller, slave = the board/RAM side.
interface ram_prog_ctrl_if #(
  parameter int WIDTH  = 8,
  parameter int ADDR_W = WIDTH / 2
);
  logic              prog_mode;
  logic              btn_wr;
  logic [WIDTH-1:0]  sw;
  logic [WIDTH-1:0]  bus;
  logic [ADDR_W-1:0] addr;
  logic              prog_en;
  logic              wr_en;
  logic              rd_en;
  logic              busy;
  logic              done;
  logic              err;

  modport master (
    input  prog_mode, btn_wr, sw, bus,
    output addr, prog_en, wr_en, rd_en, busy, done, err
  );

  modport slave (
    output prog_mode, btn_wr, sw, bus,
    input  addr, prog_en, wr_en, rd_en, busy, done, err
  );
endinterface

// File: rtl/btn_sync_edge.sv
// Pushbutton conditioner: 2-flop synchronizer followed by a registered
// rising-edge detector. One press gives one 1-cycle pulse, 3 clocks after
// the raw input rises.
//   clk, rst_n : clock, synchronous active-low reset
//   din        : raw asynchronous button
//   pulse      : single-cycle press strobe
module btn_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic pulse
);
  // sh[0], sh[1] synchronize; sh[2] holds the previous synchronized level.
  logic [2:0] sh;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sh    <= '0;
      pulse <= 1'b0;
    end else begin
      sh    <= {sh[1:0], din};
      pulse <= sh[1] & ~sh[2];
    end
  end
endmodule

// File: rtl/ram_prog_ctrl.sv
// RAM programming controller: each debounced write press stores sw at the
// current address, reads it back over the CPU bus to verify, then advances
// the address (mod 16). done marks a write to the last location, err marks
// any readback mismatch; both are sticky until the next arm.
//   clk, rst_n : clock, synchronous active-low reset
//   p          : ram_prog_ctrl_if master port (see interface header)
module ram_prog_ctrl
  import cpu_pkg::*;
#(
  parameter int WIDTH  = CPU_WIDTH,
  parameter int ADDR_W = WIDTH / 2
) (
  input logic          clk,
  input logic          rst_n,
  ram_prog_ctrl_if.master p
);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(RAM_DEPTH - 1);

  prog_state_e       state;
  logic              wr_req;
  logic [WIDTH-1:0]  exp_data;
  logic [ADDR_W-1:0] addr_q;
  logic              prog_en_q, wr_en_q, rd_en_q, busy_q, done_q, err_q;

  btn_sync_edge u_btn (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (p.btn_wr),
    .pulse (wr_req)
  );

  // Outputs are registered alongside the state so they change on the same
  // edge as the state they belong to.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      addr_q    <= '0;
      exp_data  <= '0;
      prog_en_q <= 1'b0;
      wr_en_q   <= 1'b0;
      rd_en_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (p.prog_mode) begin
            state     <= ARMED;
            addr_q    <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            prog_en_q <= 1'b1;
          end
        end
        ARMED: begin
          // Leaving programming mode wins over a simultaneous press.
          if (!p.prog_mode) begin
            state     <= IDLE;
            prog_en_q <= 1'b0;
          end else if (wr_req) begin
            state   <= WRITE;
            wr_en_q <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        WRITE: begin
          exp_data <= p.sw;
          state    <= VERIFY;
          wr_en_q  <= 1'b0;
          rd_en_q  <= 1'b1;
        end
        VERIFY: begin
          if (p.bus != exp_data) err_q <= 1'b1;
          state   <= INC;
          rd_en_q <= 1'b0;
        end
        INC: begin
          addr_q <= addr_q + 1'b1;
          if (addr_q == LAST_ADDR) done_q <= 1'b1;
          busy_q <= 1'b0;
          // A prog_mode drop during the sequence only takes effect here.
          if (p.prog_mode) begin
            state <= ARMED;
          end else begin
            state     <= IDLE;
            prog_en_q <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          prog_en_q <= 1'b0;
          wr_en_q   <= 1'b0;
          rd_en_q   <= 1'b0;
          busy_q    <= 1'b0;
        end
      endcase
    end
  end

  assign p.addr    = addr_q;
  assign p.prog_en = prog_en_q;
  assign p.wr_en   = wr_en_q;
  assign p.rd_en   = rd_en_q;
  assign p.busy    = busy_q;
  assign p.done    = done_q;
  assign p.err     = err_q;
endmodule

// File: tb/tb_ram_prog_ctrl.sv
module tb_ram_prog_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ram_prog_ctrl_if #(.WIDTH(8), .ADDR_W(4)) itf ();

  ram_prog_ctrl #(.WIDTH(8), .ADDR_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .p     (itf)
  );

  // RAM model: written on wr_en, drives the bus while rd_en.
  logic [7:0] ram [16];
  logic       bad = 1'b0;
  int         wr_cnt = 0;
  int         checks = 0;
  int         errors = 0;

  always @(posedge clk) begin
    if (itf.wr_en) begin
      ram[itf.addr] <= itf.sw;
      wr_cnt <= wr_cnt + 1;
    end
  end

  assign itf.bus = itf.rd_en ? (bad ? 8'h00 : ram[itf.addr]) : 8'h00;

  always @(negedge clk) begin
    if (itf.wr_en && itf.rd_en) begin
      errors++;
      $display("FAIL wr_rd_overlap got wr_en=1 rd_en=1 want never both");
    end
  end

  typedef struct {
    logic [7:0] sw;
    logic       bad;
    logic [3:0] waddr;
    logic [3:0] naddr;
    logic       err;
    logic       done;
  } vec_t;

  vec_t vecs [18];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic press(input int hold);
    itf.btn_wr = 1'b1;
    repeat (hold) @(negedge clk);
    itf.btn_wr = 1'b0;
  endtask

  // Waits (bounded) for the WRITE cycle; leaves time at that negedge.
  task automatic wait_wr(input string name);
    bit seen = 0;
    for (int k = 0; k < 20; k++) begin
      if (itf.wr_en) begin seen = 1; break; end
      @(negedge clk);
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s_timeout got no wr_en want wr_en within 20 cycles", name);
    end
  endtask

  function automatic logic [9:0] outs();
    return {itf.addr, itf.prog_en, itf.wr_en, itf.rd_en, itf.busy, itf.done, itf.err};
  endfunction

  initial begin
    int c0;
    itf.prog_mode = 1'b0;
    itf.btn_wr    = 1'b0;
    itf.sw        = 8'h00;

    // Vector table: A5 at addr 0, re-arm, 16-location fill, then a bad
    // readback followed by a good write (err and done stay sticky).
    vecs[0] = '{sw: 8'hA5, bad: 1'b0, waddr: 4'd0, naddr: 4'd1, err: 1'b0, done: 1'b0};
    for (int i = 0; i < 16; i++)
      vecs[i+1] = '{sw: 8'(i*3), bad: 1'b0, waddr: 4'(i), naddr: 4'(i+1),
                    err: 1'b0, done: (i == 15)};
    vecs[17] = '{sw: 8'hFF, bad: 1'b1, waddr: 4'd0, naddr: 4'd1, err: 1'b1, done: 1'b1};

    repeat (3) @(negedge clk);
    chk("reset_outputs", 32'(outs()), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_no_prog", 32'(outs()), 32'h0);

    itf.prog_mode = 1'b1;
    @(negedge clk);
    chk("armed_prog_en", {itf.prog_en, itf.busy}, 2'b10);

    for (int v = 0; v < 18; v++) begin
      if (v == 1) begin
        // Re-arm so the 16-press fill starts at address 0.
        itf.prog_mode = 1'b0;
        @(negedge clk);
        itf.prog_mode = 1'b1;
        @(negedge clk);
        chk("rearm_addr0", itf.addr, 0);
      end
      itf.sw = vecs[v].sw;
      bad    = vecs[v].bad;
      press(3);
      wait_wr($sformatf("vec%0d", v));
      chk($sformatf("vec%0d_waddr", v), itf.addr, vecs[v].waddr);
      @(negedge clk);
      chk($sformatf("vec%0d_verify", v), {itf.rd_en, itf.wr_en, itf.busy}, 3'b101);
      @(negedge clk);
      chk($sformatf("vec%0d_inc", v), {itf.busy, itf.rd_en, itf.wr_en}, 3'b100);
      @(negedge clk);
      bad = 1'b0;
      chk($sformatf("vec%0d_state", v),
          {itf.addr, itf.busy, itf.err, itf.done, itf.prog_en},
          {vecs[v].naddr, 1'b0, vecs[v].err, vecs[v].done, 1'b1});
      chk($sformatf("vec%0d_ram", v), ram[vecs[v].waddr], vecs[v].sw);
      if (v == 16)
        for (int i = 0; i < 16; i++) chk($sformatf("fill_ram%0d", i), ram[i], i*3);
    end

    // Good write after the bad one: err stays set until re-arm.
    itf.sw = 8'h12;
    press(3);
    wait_wr("sticky");
    repeat (3) @(negedge clk);
    chk("err_sticky", {itf.addr, itf.err, itf.done}, {4'd2, 2'b11});
    itf.prog_mode = 1'b0;
    @(negedge clk);
    itf.prog_mode = 1'b1;
    @(negedge clk);
    chk("rearm_clears", {itf.addr, itf.err, itf.done, itf.prog_en}, {4'd0, 3'b001});

    // Long hold: exactly one write.
    c0 = wr_cnt;
    press(50);
    repeat (5) @(negedge clk);
    chk("hold50_writes", wr_cnt - c0, 1);
    // Short press then a 2-cycle bounce that lands while busy: dropped.
    c0 = wr_cnt;
    itf.btn_wr = 1'b1;
    @(negedge clk);
    itf.btn_wr = 1'b0;
    @(negedge clk);
    press(2);
    repeat (20) @(negedge clk);
    chk("bounce_writes", wr_cnt - c0, 1);
    chk("bounce_addr", itf.addr, 2);

    // prog_mode dropped in WRITE: sequence completes, then IDLE.
    press(3);
    wait_wr("drop");
    itf.prog_mode = 1'b0;
    @(negedge clk);
    chk("drop_verify", {itf.rd_en, itf.busy}, 2'b11);
    @(negedge clk);
    chk("drop_inc", {itf.busy, itf.prog_en}, 2'b11);
    @(negedge clk);
    chk("drop_idle", {itf.addr, itf.busy, itf.prog_en}, {4'd3, 2'b00});

    // Reset in VERIFY aborts; no write follows without a new press.
    itf.prog_mode = 1'b1;
    @(negedge clk);
    press(3);
    wait_wr("rst");
    @(negedge clk);
    chk("rst_in_verify", itf.rd_en, 1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_abort_outputs", 32'(outs()), 32'h0);
    rst_n = 1'b1;
    c0 = wr_cnt;
    repeat (20) @(negedge clk);
    chk("rst_no_write", wr_cnt - c0, 0);
    chk("rst_rearmed", {itf.prog_en, itf.addr}, {1'b1, 4'd0});
    itf.sw = 8'h5A;
    press(3);
    wait_wr("post_rst");
    chk("post_rst_addr", itf.addr, 0);
    repeat (3) @(negedge clk);
    chk("post_rst_ram", ram[0], 8'h5A);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
